// File: rtl/cpu_pipe_pkg.sv
// Shared types for the CPU inter-stage pipeline registers: occupancy states,
// control-bit positions and the default-width payload bundle.
package cpu_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_st_t;

  localparam int CTRL_BYPASS = 0;
  localparam int CTRL_MEM_WE = 1;
  localparam int CTRL_AUX    = 2;

  localparam int DEF_CTRL_W = 3;
  localparam int DEF_WA_W   = 5;
  localparam int DEF_DATA_W = 16;

  typedef struct packed {
    logic [DEF_CTRL_W-1:0] ctrl;
    logic [DEF_WA_W-1:0]   wa;
    logic [DEF_DATA_W-1:0] data;
  } pipe_bundle_t;

endpackage

// File: rtl/pipe_stage_entry.sv
// One valid+payload slot. Clear wins over load and zeroes valid and ctrl only,
// so a cleared slot can never carry a live write enable.
module pipe_stage_entry
  import cpu_pipe_pkg::*;
#(
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int WA_W   = DEF_WA_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [WA_W-1:0]   wa_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [WA_W-1:0]   wa_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [WA_W-1:0]   wa_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      wa_q    <= '0;
      data_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_i;
      wa_q    <= wa_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign wa_o    = wa_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry skid,
// synchronous flush and saturating stall counter.
module pipe_stage_skid
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int WA_W   = 5,
  parameter int CTRL_W = 3,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [WA_W-1:0]   in_wa,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [WA_W-1:0]   out_wa,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              main_v, skid_v;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [WA_W-1:0]   skid_wa;
  logic [DATA_W-1:0] skid_data;
  logic              main_load, main_clear, main_sel_skid;
  logic              skid_load, skid_clear;
  logic [CTRL_W-1:0] main_ctrl_d;
  logic [WA_W-1:0]   main_wa_d;
  logic [DATA_W-1:0] main_data_d;
  logic              acc, pop;
  pipe_st_t          st;
  logic [CNT_W-1:0]  stall_q, stall_d;

  assign acc = in_valid && in_ready;
  assign pop = main_v && out_ready;

  // Skid-valid without main-valid is unreachable; decoding it as EMPTY lets it self-clear.
  always_comb begin
    st = ST_EMPTY;
    if (main_v && skid_v) st = ST_TWO;
    else if (main_v)      st = ST_ONE;
  end

  always_comb begin
    main_load     = 1'b0;
    main_clear    = 1'b0;
    main_sel_skid = 1'b0;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else if (SKID != 0) begin
      case (st)
        ST_EMPTY: begin
          main_load  = acc;
          skid_clear = skid_v;
        end
        ST_ONE: begin
          if (acc && !pop)     skid_load  = 1'b1;
          else if (acc && pop) main_load  = 1'b1;
          else if (pop)        main_clear = 1'b1;
        end
        ST_TWO: begin
          if (pop) begin
            main_load     = 1'b1;
            main_sel_skid = 1'b1;
            skid_clear    = 1'b1;
          end
        end
        default: begin
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end else begin
      if (acc)      main_load  = 1'b1;
      else if (pop) main_clear = 1'b1;
    end
  end

  assign main_ctrl_d = main_sel_skid ? skid_ctrl : in_ctrl;
  assign main_wa_d   = main_sel_skid ? skid_wa   : in_wa;
  assign main_data_d = main_sel_skid ? skid_data : in_data;

  pipe_stage_entry #(.CTRL_W(CTRL_W), .WA_W(WA_W), .DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .load_i  (main_load),
    .clear_i (main_clear),
    .ctrl_i  (main_ctrl_d),
    .wa_i    (main_wa_d),
    .data_i  (main_data_d),
    .valid_o (main_v),
    .ctrl_o  (out_ctrl),
    .wa_o    (out_wa),
    .data_o  (out_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_stage_entry #(.CTRL_W(CTRL_W), .WA_W(WA_W), .DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .ctrl_i  (in_ctrl),
        .wa_i    (in_wa),
        .data_i  (in_data),
        .valid_o (skid_v),
        .ctrl_o  (skid_ctrl),
        .wa_o    (skid_wa),
        .data_o  (skid_data)
      );
      // Registered ready: depends only on the skid flop, never on out_ready.
      assign in_ready = !skid_v;
    end else begin : g_noskid
      assign skid_v    = 1'b0;
      assign skid_ctrl = '0;
      assign skid_wa   = '0;
      assign skid_data = '0;
      assign in_ready  = !main_v || out_ready;
    end
  endgenerate

  assign out_valid = main_v;

  always_comb begin
    stall_d = stall_q;
    if (main_v && !out_ready && (stall_q != CNT_MAX)) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench: skid variant, single-register variant and a 4-bit stall counter variant.
module tb_pipe_stage_skid;
  import cpu_pipe_pkg::*;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // skid instance (SKID=1)
  logic s_rst, s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [2:0] s_in_ctrl, s_out_ctrl;
  logic [4:0] s_in_wa, s_out_wa;
  logic [15:0] s_in_data, s_out_data, s_stall;
  // single-register instance (SKID=0)
  logic r_rst, r_flush, r_in_valid, r_in_ready, r_out_valid, r_out_ready;
  logic [2:0] r_in_ctrl, r_out_ctrl;
  logic [4:0] r_in_wa, r_out_wa;
  logic [15:0] r_in_data, r_out_data, r_stall;
  // 4-bit counter instance
  logic c_rst, c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [2:0] c_in_ctrl, c_out_ctrl;
  logic [4:0] c_in_wa, c_out_wa;
  logic [15:0] c_in_data, c_out_data;
  logic [3:0] c_stall;

  pipe_stage_skid #(.SKID(1)) u_skid (
    .clk(clk), .rst(s_rst), .flush(s_flush), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_ctrl(s_in_ctrl), .in_wa(s_in_wa), .in_data(s_in_data), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_ctrl(s_out_ctrl), .out_wa(s_out_wa), .out_data(s_out_data),
    .stall_cnt(s_stall));

  pipe_stage_skid #(.SKID(0)) u_reg (
    .clk(clk), .rst(r_rst), .flush(r_flush), .in_valid(r_in_valid), .in_ready(r_in_ready),
    .in_ctrl(r_in_ctrl), .in_wa(r_in_wa), .in_data(r_in_data), .out_valid(r_out_valid),
    .out_ready(r_out_ready), .out_ctrl(r_out_ctrl), .out_wa(r_out_wa), .out_data(r_out_data),
    .stall_cnt(r_stall));

  pipe_stage_skid #(.SKID(1), .CNT_W(4)) u_cnt (
    .clk(clk), .rst(c_rst), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_ctrl(c_in_ctrl), .in_wa(c_in_wa), .in_data(c_in_data), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_ctrl(c_out_ctrl), .out_wa(c_out_wa), .out_data(c_out_data),
    .stall_cnt(c_stall));

  int n_cmp = 0;
  int n_err = 0;
  pipe_bundle_t q_s[$];
  pipe_bundle_t q_r[$];

  typedef struct {
    logic        iv;
    logic        rdy;
    logic [15:0] d;
    logic        e_ir;
    logic        e_ov;
    logic [15:0] e_od;
    logic [15:0] e_st;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Handshakes seen on the falling edge happen on the following rising edge.
  task automatic mon(input string name, input logic rst_v, input logic fl, input logic iv,
                     input logic ir, input logic ov, input logic ordy, input pipe_bundle_t in_b,
                     input pipe_bundle_t out_b, inout pipe_bundle_t q[$]);
    pipe_bundle_t e;
    if (!rst_v || fl) begin
      q.delete();
    end else begin
      if (ov && ordy) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL %s_unexpected: got %0h want no output", name, out_b);
        end else begin
          e = q.pop_front();
          chk({name, "_order"}, 32'(out_b), 32'(e));
        end
      end
      if (iv && ir) q.push_back(in_b);
    end
  endtask

  task automatic step();
    @(negedge clk);
    mon("skid_sb", s_rst, s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready,
        {s_in_ctrl, s_in_wa, s_in_data}, {s_out_ctrl, s_out_wa, s_out_data}, q_s);
    mon("reg_sb", r_rst, r_flush, r_in_valid, r_in_ready, r_out_valid, r_out_ready,
        {r_in_ctrl, r_in_wa, r_in_data}, {r_out_ctrl, r_out_wa, r_out_data}, q_r);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // iv, rdy, data, exp in_ready, exp out_valid, exp out_data, exp stall
    tbl[0]  = '{1'b1, 1'b1, 16'h0001, 1'b1, 1'b1, 16'h0001, 16'd0};
    tbl[1]  = '{1'b1, 1'b1, 16'h0002, 1'b1, 1'b1, 16'h0002, 16'd0};
    tbl[2]  = '{1'b1, 1'b1, 16'h0003, 1'b1, 1'b1, 16'h0003, 16'd0};
    tbl[3]  = '{1'b1, 1'b1, 16'h0004, 1'b1, 1'b1, 16'h0004, 16'd0};
    tbl[4]  = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h0004, 16'd0};
    tbl[5]  = '{1'b1, 1'b0, 16'h00AA, 1'b1, 1'b1, 16'h00AA, 16'd0};
    tbl[6]  = '{1'b1, 1'b0, 16'h00BB, 1'b0, 1'b1, 16'h00AA, 16'd1};
    tbl[7]  = '{1'b1, 1'b0, 16'h00CC, 1'b0, 1'b1, 16'h00AA, 16'd2};
    tbl[8]  = '{1'b1, 1'b0, 16'h00CC, 1'b0, 1'b1, 16'h00AA, 16'd3};
    tbl[9]  = '{1'b1, 1'b0, 16'h00CC, 1'b0, 1'b1, 16'h00AA, 16'd4};
    tbl[10] = '{1'b1, 1'b0, 16'h00CC, 1'b0, 1'b1, 16'h00AA, 16'd5};
    tbl[11] = '{1'b1, 1'b1, 16'h00CC, 1'b1, 1'b1, 16'h00BB, 16'd5};
    tbl[12] = '{1'b1, 1'b1, 16'h00CC, 1'b1, 1'b1, 16'h00CC, 16'd5};
    tbl[13] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h00CC, 16'd5};

    {s_rst, s_flush, s_in_valid, s_out_ready, s_in_ctrl, s_in_wa, s_in_data} = '0;
    {r_rst, r_flush, r_in_valid, r_out_ready, r_in_ctrl, r_in_wa, r_in_data} = '0;
    {c_rst, c_flush, c_in_valid, c_out_ready, c_in_ctrl, c_in_wa, c_in_data} = '0;
    #2;
    chk("rst_out_valid", 32'(s_out_valid), 32'd0);
    chk("rst_out_ctrl",  32'(s_out_ctrl),  32'd0);
    chk("rst_out_wa",    32'(s_out_wa),    32'd0);
    chk("rst_out_data",  32'(s_out_data),  32'd0);
    chk("rst_in_ready",  32'(s_in_ready),  32'd1);
    chk("rst_stall",     32'(s_stall),     32'd0);
    chk("rst_reg_in_ready", 32'(r_in_ready), 32'd1);
    @(posedge clk);
    #1;
    s_rst = 1'b1;
    r_rst = 1'b1;
    c_rst = 1'b1;

    // streaming and backpressure
    s_in_ctrl = 3'b111;
    for (int i = 0; i < 14; i++) begin
      s_in_valid  = tbl[i].iv;
      s_out_ready = tbl[i].rdy;
      s_in_data   = tbl[i].d;
      s_in_wa     = tbl[i].d[4:0];
      step();
      chk($sformatf("vec%0d_in_ready", i),  32'(s_in_ready),  32'(tbl[i].e_ir));
      chk($sformatf("vec%0d_out_valid", i), 32'(s_out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("vec%0d_out_data", i),  32'(s_out_data),  32'(tbl[i].e_od));
      chk($sformatf("vec%0d_stall", i),     32'(s_stall),     32'(tbl[i].e_st));
      if (!tbl[i].e_ov) chk($sformatf("vec%0d_bubble_ctrl", i), 32'(s_out_ctrl), 32'd0);
    end

    // flush while two entries are held and a third is offered
    s_out_ready = 1'b0;
    s_in_valid = 1'b1; s_in_data = 16'h0011; s_in_wa = 5'd11;
    step();
    s_in_data = 16'h0022; s_in_wa = 5'd12;
    step();
    chk("pre_flush_in_ready", 32'(s_in_ready), 32'd0);
    s_flush = 1'b1; s_in_ctrl = 3'b010; s_in_data = 16'h0033; s_in_wa = 5'd13;
    step();
    s_flush = 1'b0; s_in_valid = 1'b0; s_in_ctrl = 3'b111;
    chk("flush_out_valid", 32'(s_out_valid), 32'd0);
    chk("flush_out_ctrl",  32'(s_out_ctrl),  32'd0);
    chk("flush_in_ready",  32'(s_in_ready),  32'd1);
    chk("flush_stall",     32'(s_stall),     32'd7);
    s_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post_flush%0d_out_valid", i), 32'(s_out_valid), 32'd0);
    end
    s_in_valid = 1'b1; s_in_data = 16'h0044; s_in_wa = 5'd14;
    step();
    s_in_valid = 1'b0;
    chk("post_flush_data", 32'(s_out_data), 32'h0044);
    step();

    // async reset between edges while two entries are held
    s_out_ready = 1'b0;
    s_in_valid = 1'b1; s_in_data = 16'h0055; s_in_wa = 5'd15;
    step();
    s_in_data = 16'h0066; s_in_wa = 5'd16;
    step();
    s_in_valid = 1'b0;
    #2;
    s_rst = 1'b0;
    #1;
    chk("arst_out_valid", 32'(s_out_valid), 32'd0);
    chk("arst_out_ctrl",  32'(s_out_ctrl),  32'd0);
    chk("arst_out_wa",    32'(s_out_wa),    32'd0);
    chk("arst_out_data",  32'(s_out_data),  32'd0);
    chk("arst_stall",     32'(s_stall),     32'd0);
    chk("arst_in_ready",  32'(s_in_ready),  32'd1);
    step();
    s_rst = 1'b1;
    s_out_ready = 1'b1;
    s_in_valid = 1'b1; s_in_data = 16'h0077; s_in_wa = 5'd17;
    step();
    s_in_valid = 1'b0;
    chk("arst_first_valid", 32'(s_out_valid), 32'd1);
    chk("arst_first_data",  32'(s_out_data),  32'h0077);
    step();
    chk("arst_drain_valid", 32'(s_out_valid), 32'd0);

    // single-register variant: in_ready follows out_ready combinationally
    r_in_ctrl = 3'b011;
    r_in_valid = 1'b1; r_in_data = 16'h0010; r_in_wa = 5'd1; r_out_ready = 1'b0;
    step();
    chk("reg_a_out_data", 32'(r_out_data), 32'h0010);
    chk("reg_a_in_ready", 32'(r_in_ready), 32'd0);
    r_out_ready = 1'b1; r_in_data = 16'h0020; r_in_wa = 5'd2;
    #1;
    chk("reg_b_in_ready", 32'(r_in_ready), 32'd1);
    step();
    chk("reg_b_out_data", 32'(r_out_data), 32'h0020);
    r_out_ready = 1'b0; r_in_data = 16'h0030; r_in_wa = 5'd3;
    #1;
    chk("reg_c_in_ready", 32'(r_in_ready), 32'd0);
    step();
    chk("reg_c_out_data", 32'(r_out_data), 32'h0020);
    chk("reg_c_stall",    32'(r_stall),    32'd1);
    r_out_ready = 1'b1;
    #1;
    chk("reg_d_in_ready", 32'(r_in_ready), 32'd1);
    step();
    chk("reg_d_out_data", 32'(r_out_data), 32'h0030);
    r_in_valid = 1'b0;
    step();
    chk("reg_e_out_valid", 32'(r_out_valid), 32'd0);

    // 4-bit stall counter saturation
    c_in_valid = 1'b1; c_in_data = 16'h00C4; c_in_ctrl = 3'b001; c_out_ready = 1'b0;
    step();
    c_in_valid = 1'b0;
    chk("cnt_start", 32'(c_stall), 32'd0);
    for (int k = 1; k <= 21; k++) begin
      step();
      chk($sformatf("cnt_k%0d", k), 32'(c_stall), (k > 15) ? 32'd15 : 32'(k));
    end

    chk("skid_sb_empty", 32'(q_s.size()), 32'd0);
    chk("reg_sb_empty",  32'(q_r.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
